// File: rtl/uvc_payload_tx.sv
// uvc_payload_tx
//   Reader side of the video FIFO. Each USB microframe (SOF rising edge seen
//   while idle and with data available) produces one UVC payload packet:
//   a 12-byte payload header (HLE, BFH, PTS, SCR) followed by up to
//   PAYLOAD_SIZE-12 pixel bytes taken from a show-ahead FIFO. Frame
//   boundaries are tracked here, and EOF is set in the header of the packet
//   that completes a frame.
//
// Ports
//   CLK_I         clock
//   RST_I         synchronous, active-high reset
//   SOF_I         SOF level from the USB device controller (rising edge used)
//   FRAME_I[7:0]  frame info from the generator, bit0 = FID
//   PTS_I[31:0]   presentation timestamp from the generator
//   FIFO_DATA_I   FIFO head byte (valid while FIFO_EMPTY_I = 0)
//   FIFO_EMPTY_I  FIFO empty
//   FIFO_RD_O     pop the FIFO head this cycle
//   EP_READY_I    endpoint accepts a byte this cycle
//   EP_DATA_O     packet byte
//   EP_VALID_O    EP_DATA_O valid
//   EP_LAST_O     EP_DATA_O is the final byte of the packet
module uvc_payload_tx #(
  parameter int unsigned PAYLOAD_SIZE = 1024,
  parameter int unsigned FRAME_SIZE   = 307200
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SOF_I,
  input  logic [7:0]  FRAME_I,
  input  logic [31:0] PTS_I,
  input  logic [7:0]  FIFO_DATA_I,
  input  logic        FIFO_EMPTY_I,
  output logic        FIFO_RD_O,
  input  logic        EP_READY_I,
  output logic [7:0]  EP_DATA_O,
  output logic        EP_VALID_O,
  output logic        EP_LAST_O
);

  localparam int unsigned DATA_MAX = PAYLOAD_SIZE - 12;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t      state_q, state_d;

  logic        sof_d0, sof_d1, sof_rise;
  logic [31:0] stc_q;
  logic [2:0]  sof_sub_q;
  logic [10:0] sof_cnt_q;
  logic [31:0] frame_cnt_q;

  logic [95:0] hdr_sr_q;
  logic [3:0]  hdr_idx_q;
  logic [15:0] data_cnt_q;
  logic [15:0] len_q;
  logic        eof_q;

  logic [31:0] remain;
  logic [15:0] len_calc;
  logic        eof_calc;
  logic        data_avail;
  logic        data_last;

  logic        unused_frame;
  assign unused_frame = ^FRAME_I[7:1];

  // Length of the next packet's data section and whether it closes the frame.
  always_comb begin
    remain = 32'(FRAME_SIZE) - frame_cnt_q;
    if (remain < 32'(DATA_MAX)) begin
      len_calc = remain[15:0];
    end else begin
      len_calc = 16'(DATA_MAX);
    end
    eof_calc = (frame_cnt_q + 32'(len_calc)) == 32'(FRAME_SIZE);
  end

  assign data_avail = ~FIFO_EMPTY_I;
  assign data_last  = (data_cnt_q == len_q - 16'd1);

  // Next state and outputs. Header bytes come from a register; data bytes are
  // a combinational pass-through of the FIFO head.
  always_comb begin
    state_d    = state_q;
    EP_VALID_O = 1'b0;
    EP_DATA_O  = '0;
    EP_LAST_O  = 1'b0;
    FIFO_RD_O  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof_rise && data_avail) begin
          state_d = HDR;
        end
      end
      HDR: begin
        EP_VALID_O = 1'b1;
        EP_DATA_O  = hdr_sr_q[7:0];
        if (EP_READY_I && hdr_idx_q == 4'd11) begin
          state_d = DATA;
        end
      end
      DATA: begin
        EP_VALID_O = data_avail;
        EP_DATA_O  = FIFO_DATA_I;
        EP_LAST_O  = data_avail & data_last;
        FIFO_RD_O  = data_avail & EP_READY_I;
        if (data_avail && EP_READY_I && data_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      sof_d0      <= 1'b0;
      sof_d1      <= 1'b0;
      sof_rise    <= 1'b0;
      stc_q       <= '0;
      sof_sub_q   <= '0;
      sof_cnt_q   <= '0;
      frame_cnt_q <= '0;
      hdr_sr_q    <= '0;
      hdr_idx_q   <= '0;
      data_cnt_q  <= '0;
      len_q       <= '0;
      eof_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      // Edge detect is registered so the first header byte appears two
      // clocks after SOF_I is first sampled high.
      sof_d0   <= SOF_I;
      sof_d1   <= sof_d0;
      sof_rise <= sof_d0 & ~sof_d1;

      stc_q <= stc_q + 32'd1;

      if (sof_rise) begin
        sof_sub_q <= sof_sub_q + 3'd1;
        if (sof_sub_q == 3'd7) begin
          sof_cnt_q <= sof_cnt_q + 11'd1;
        end
      end

      case (state_q)
        IDLE: begin
          if (sof_rise && data_avail) begin
            // Whole header latched at once, byte 0 in the low byte, shifted
            // out one byte per transfer.
            hdr_sr_q   <= {5'b0, sof_cnt_q,
                           stc_q,
                           PTS_I,
                           8'h8C | {6'b0, eof_calc, FRAME_I[0]},
                           8'h0C};
            hdr_idx_q  <= '0;
            data_cnt_q <= '0;
            len_q      <= len_calc;
            eof_q      <= eof_calc;
          end
        end
        HDR: begin
          if (EP_READY_I) begin
            hdr_sr_q  <= {8'h00, hdr_sr_q[95:8]};
            hdr_idx_q <= hdr_idx_q + 4'd1;
          end
        end
        DATA: begin
          if (data_avail && EP_READY_I) begin
            data_cnt_q <= data_cnt_q + 16'd1;
            if (data_last) begin
              frame_cnt_q <= eof_q ? '0 : frame_cnt_q + 32'(len_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uvc_payload_tx.sv
module tb_uvc_payload_tx;

  localparam int P    = 1024;
  localparam int F    = 3000;
  localparam int DMAX = P - 12;

  logic        clk = 1'b0;
  logic        RST_I = 1'b1;
  logic        SOF_I = 1'b0;
  logic [7:0]  FRAME_I = '0;
  logic [31:0] PTS_I = '0;
  logic [7:0]  FIFO_DATA_I = '0;
  logic        FIFO_EMPTY_I = 1'b1;
  logic        FIFO_RD_O;
  logic        EP_READY_I = 1'b0;
  logic [7:0]  EP_DATA_O;
  logic        EP_VALID_O;
  logic        EP_LAST_O;

  uvc_payload_tx #(.PAYLOAD_SIZE(P), .FRAME_SIZE(F)) dut (
    .CLK_I       (clk),
    .RST_I       (RST_I),
    .SOF_I       (SOF_I),
    .FRAME_I     (FRAME_I),
    .PTS_I       (PTS_I),
    .FIFO_DATA_I (FIFO_DATA_I),
    .FIFO_EMPTY_I(FIFO_EMPTY_I),
    .FIFO_RD_O   (FIFO_RD_O),
    .EP_READY_I  (EP_READY_I),
    .EP_DATA_O   (EP_DATA_O),
    .EP_VALID_O  (EP_VALID_O),
    .EP_LAST_O   (EP_LAST_O)
  );

  always #5 clk = ~clk;

  // Clock edges since reset released: the expected timestamp clock.
  int unsigned tb_edges;
  always @(posedge clk) begin
    if (RST_I) tb_edges <= 0;
    else       tb_edges <= tb_edges + 1;
  end

  typedef struct {
    bit rnd_ready;
    int gap_at;
    bit mid_sof;
    int exp_len;
    bit exp_eof;
  } row_t;

  row_t        tab[5];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  fifo_q[$];
  int          fpos = 0;
  int          n_rise = 0;
  int unsigned gen = 0;
  bit          force_empty = 0;
  bit          rd_prev = 0;
  bit          sof_prev = 0;
  logic        s_valid, s_last, s_rd;
  logic [7:0]  s_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs after the falling edge, then sample outputs.
  task automatic tick(input bit sof, input bit rdy);
    @(negedge clk);
    if (rd_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
    SOF_I        = sof;
    EP_READY_I   = rdy;
    FIFO_EMPTY_I = force_empty || (fifo_q.size() == 0);
    FIFO_DATA_I  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    if (sof && !sof_prev) n_rise++;
    sof_prev = sof;
    #1;
    s_valid = EP_VALID_O;
    s_data  = EP_DATA_O;
    s_last  = EP_LAST_O;
    s_rd    = FIFO_RD_O;
    rd_prev = s_rd;
  endtask

  function automatic bit pick_ready(input bit rnd);
    return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic sof_empty(input int pulses);
    int bad;
    bad = 0;
    force_empty = 1;
    for (int i = 0; i < pulses; i++) begin
      tick(1, 1); if (s_valid || s_rd) bad++;
      tick(0, 1); if (s_valid || s_rd) bad++;
    end
    repeat (4) begin
      tick(0, 1); if (s_valid || s_rd) bad++;
    end
    force_empty = 0;
    check("empty-FIFO SOF starts nothing", bad, 0);
  endtask

  task automatic run_packet(input string tag, input bit rnd_ready, input int gap_at,
                            input bit mid_sof, input int rst_at,
                            input int tab_len, input int tab_eof);
    int          len, exp_sof, lat, cyc, dcount, next_sof_at, gap_left, gap_n, gap_bad;
    int          rd_cnt, rd_bad, unstable, dmis, last_pos, bad;
    bit          eof, fid, done, gap_started, in_gap, sof_now, rdy, xfer;
    logic [31:0] pts, stc_exp;
    logic [7:0]  exp_d[$];
    logic [7:0]  got[$];
    logic        pv, pr, pl;
    logic [7:0]  pd;

    while (fifo_q.size() < 1200) begin
      fifo_q.push_back(8'((gen * 37) ^ (gen >> 5)));
      gen++;
    end
    // Reference: bytes left in the frame versus the room in one packet.
    len = (F - fpos < DMAX) ? F - fpos : DMAX;
    eof = (fpos + len == F);
    if (tab_len >= 0) begin
      len = tab_len;
      eof = tab_eof[0];
    end
    for (int k = 0; k < len; k++) exp_d.push_back(fifo_q[k]);
    pts     = $urandom;
    PTS_I   = pts;
    FRAME_I = 8'($urandom);
    fid     = FRAME_I[0];
    exp_sof = (n_rise / 8) % 2048;
    force_empty = 0;

    tick(1, pick_ready(rnd_ready));
    lat = 0;
    while (!s_valid && lat < 20) begin
      tick(0, pick_ready(rnd_ready));
      lat++;
    end
    check({tag, " SOF-to-valid latency"}, lat, 3);
    stc_exp = tb_edges - 1;

    cyc = 0; done = 0; next_sof_at = 100; gap_left = 0; gap_n = 0; gap_bad = 0;
    gap_started = 0; in_gap = 0; rd_cnt = 0; rd_bad = 0; unstable = 0; last_pos = -1;
    pv = 0; pr = 0; pl = 0; pd = 0;
    while (!done && cyc < 8000) begin
      if (pv && !pr && s_valid && (s_data !== pd || s_last !== pl)) unstable++;
      if (in_gap) begin
        gap_n++;
        if (s_valid || s_rd) gap_bad++;
      end
      xfer = s_valid && EP_READY_I;
      if (s_rd !== (xfer && got.size() >= 12)) rd_bad++;
      if (s_rd) rd_cnt++;
      if (xfer) begin
        got.push_back(s_data);
        if (s_last) begin
          last_pos = got.size();
          done = 1;
        end
      end
      pv = s_valid; pr = EP_READY_I; pd = s_data; pl = s_last;
      if (done) break;

      dcount = got.size() - 12;
      if (rst_at >= 0 && dcount >= rst_at) begin
        RST_I = 1'b1;
        tick(0, 0);
        check({tag, " outputs after reset"}, {s_valid, s_last, s_rd, s_data}, 0);
        RST_I = 1'b0;
        bad = 0;
        repeat (10) begin
          tick(0, 1);
          if (s_valid || s_rd) bad++;
        end
        check({tag, " quiet after reset"}, bad, 0);
        fpos = 0;
        n_rise = 0;
        return;
      end
      sof_now = 0;
      if (mid_sof && dcount >= next_sof_at) begin
        sof_now = 1;
        next_sof_at = (next_sof_at >= 200) ? 1 << 30 : next_sof_at + 100;
      end
      if (gap_at >= 0 && !gap_started && dcount >= gap_at) begin
        gap_started = 1;
        gap_left = 50;
      end
      force_empty = (gap_left > 0);
      in_gap = force_empty;
      if (gap_left > 0) gap_left--;
      rdy = pick_ready(rnd_ready);
      tick(sof_now, rdy);
      cyc++;
    end
    force_empty = 0;

    check({tag, " packet bytes"}, got.size(), 12 + len);
    while (got.size() < 12) got.push_back(8'h00);
    check({tag, " hdr HLE"}, got[0], 8'h0C);
    check({tag, " hdr BFH"}, got[1], 8'h8C | {6'b0, eof, fid});
    check({tag, " hdr PTS"}, {got[5], got[4], got[3], got[2]}, pts);
    check({tag, " hdr STC"}, {got[9], got[8], got[7], got[6]}, stc_exp);
    check({tag, " hdr SOF count"}, {got[11], got[10]}, {5'b0, 11'(exp_sof)});
    dmis = 0;
    for (int k = 0; k < len; k++) begin
      if (k + 12 >= got.size() || got[k + 12] !== exp_d[k]) dmis++;
    end
    check({tag, " data mismatches"}, dmis, 0);
    check({tag, " EP_LAST_O position"}, last_pos, 12 + len);
    check({tag, " FIFO pops"}, rd_cnt, len);
    check({tag, " FIFO_RD_O misuse"}, rd_bad, 0);
    check({tag, " hold while not ready"}, unstable, 0);
    if (gap_at >= 0) begin
      check({tag, " gap cycles"}, gap_n, 50);
      check({tag, " activity during gap"}, gap_bad, 0);
    end
    bad = 0;
    repeat (8) begin
      tick(0, 1);
      if (s_valid || s_rd) bad++;
    end
    check({tag, " idle after packet"}, bad, 0);
    fpos = eof ? 0 : fpos + len;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rnd_ready, gap_at, mid_sof, exp_len, exp_eof  (frame of 3000 bytes)
    tab[0] = '{0, -1, 0, 1012, 0};
    tab[1] = '{1, -1, 0, 1012, 0};
    tab[2] = '{0, 300, 1, 976, 1};
    tab[3] = '{0, -1, 0, 1012, 0};
    tab[4] = '{1, 400, 0, 1012, 0};

    RST_I = 1'b1;
    repeat (3) tick(0, 1);
    check("reset outputs", {s_valid, s_last, s_rd, s_data}, 0);
    RST_I = 1'b0;
    repeat (3) tick(0, 1);

    for (int i = 0; i < 5; i++) begin
      run_packet($sformatf("pkt%0d", i), tab[i].rnd_ready, tab[i].gap_at,
                 tab[i].mid_sof, -1, tab[i].exp_len, 32'(tab[i].exp_eof));
    end

    // SOF count reaches 2047 in the next header, then wraps to 0.
    sof_empty(16376 - n_rise);
    run_packet("sof2047", 0, -1, 0, -1, -1, -1);
    sof_empty(16384 - n_rise);
    run_packet("sofwrap", 0, -1, 0, -1, -1, -1);

    run_packet("reset_mid", 0, -1, 0, 500, -1, -1);
    run_packet("after_reset", 0, -1, 0, -1, 1012, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
